cpu_run_ctrl: RTL and testbench

Synthesisable run controller for the cpu core(s), taking over the reset-pulse and timeout sequencing that the bench currently hard-codes with delays.
- Holds the CPU(s) in reset for a parametrised number of cycles, then lets them run.
- Counts run cycles and terminates the run on all-cores-halted (pass), any fault, or timeout.
- Reports a sticky status, a cycle count and a per-core halted mask, for use by benches and by an FPGA top level.

---
 rtl/cpu_run_ctrl.sv | 116 +++++++++++
 tb/tb_cpu_run_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run controller for one or more cpu cores.
// Holds the cores in reset for RESET_CYCLES cycles after a start request. It then lets
// them run and counts run cycles. The run ends when every core has halted (pass), when
// any core faults, or at timeout. The result stays in a sticky status until the next
// start or a reset of this block.
//
// Ports:
//   clk          - system clock, rising edge
//   reset        - synchronous active-high reset of this block
//   start        - single-cycle run request, honoured in IDLE or DONE only
//   halt         - per-core halted level
//   fault        - per-core fault level
//   cpu_reset    - registered reset to the cores
//   running      - high while in RUN
//   done         - high while in DONE
//   status       - 00 none, 01 pass, 10 fault, 11 timeout
//   cycles       - RUN cycles of the current/last run
//   halted_mask  - sticky OR of halt during RUN
module cpu_run_ctrl #(
  parameter int unsigned NUM_CORES      = 1,
  parameter int unsigned RESET_CYCLES   = 2,
  parameter int unsigned TIMEOUT_CYCLES = 250,
  parameter int unsigned CNT_W          = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [NUM_CORES-1:0] halt,
  input  logic [NUM_CORES-1:0] fault,
  output logic                 cpu_reset,
  output logic                 running,
  output logic                 done,
  output logic [1:0]           status,
  output logic [CNT_W-1:0]     cycles,
  output logic [NUM_CORES-1:0] halted_mask
);

  localparam int unsigned RstW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  localparam logic [1:0] StatNone    = 2'b00;
  localparam logic [1:0] StatPass    = 2'b01;
  localparam logic [1:0] StatFault   = 2'b10;
  localparam logic [1:0] StatTimeout = 2'b11;

  typedef enum logic [1:0] {StIdle, StReset, StRun, StDone} state_e;

  state_e            state;
  logic [RstW-1:0]   rst_cnt;
  logic [NUM_CORES-1:0] mask_next;
  logic              any_fault;
  logic              all_halted;
  logic              timeout_hit;

  // Termination is judged on this edge's inputs, so a halt arriving in the
  // last cycle still completes the mask.
  assign mask_next   = halted_mask | halt;
  assign any_fault   = |fault;
  assign all_halted  = &mask_next;
  assign timeout_hit = (cycles == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= StIdle;
      rst_cnt     <= '0;
      cpu_reset   <= 1'b1;
      running     <= 1'b0;
      done        <= 1'b0;
      status      <= StatNone;
      cycles      <= '0;
      halted_mask <= '0;
    end else begin
      case (state)
        StIdle, StDone: begin
          if (start) begin
            state       <= StReset;
            rst_cnt     <= '0;
            cpu_reset   <= 1'b1;
            running     <= 1'b0;
            done        <= 1'b0;
            status      <= StatNone;
            cycles      <= '0;
            halted_mask <= '0;
          end
        end

        StReset: begin
          if (rst_cnt == RstW'(RESET_CYCLES - 1)) begin
            state     <= StRun;
            cpu_reset <= 1'b0;
            running   <= 1'b1;
          end else begin
            rst_cnt <= rst_cnt + RstW'(1);
          end
        end

        StRun: begin
          // The terminating cycle is counted too.
          cycles      <= cycles + CNT_W'(1);
          halted_mask <= mask_next;
          if (any_fault || all_halted || timeout_hit) begin
            state     <= StDone;
            done      <= 1'b1;
            running   <= 1'b0;
            cpu_reset <= 1'b1;
            if (any_fault)       status <= StatFault;
            else if (all_halted) status <= StatPass;
            else                 status <= StatTimeout;
          end
        end

        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Testbench for cpu_run_ctrl. Two instances: defaults (a_*) and NUM_CORES=3 (b_*).
// Expected run results are pushed to a per-instance queue when the terminating
// stimulus is issued; monitors pop and compare when done rises.
module tb_cpu_run_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_reset, a_start;
  logic [0:0]  a_halt, a_fault;
  logic        a_cpu_reset, a_running, a_done;
  logic [1:0]  a_status;
  logic [15:0] a_cycles;
  logic [0:0]  a_halted_mask;

  logic        b_reset, b_start;
  logic [2:0]  b_halt, b_fault;
  logic        b_cpu_reset, b_running, b_done;
  logic [1:0]  b_status;
  logic [15:0] b_cycles;
  logic [2:0]  b_halted_mask;

  cpu_run_ctrl u_dut_a (
    .clk(clk), .reset(a_reset), .start(a_start), .halt(a_halt), .fault(a_fault),
    .cpu_reset(a_cpu_reset), .running(a_running), .done(a_done), .status(a_status),
    .cycles(a_cycles), .halted_mask(a_halted_mask)
  );

  cpu_run_ctrl #(.NUM_CORES(3)) u_dut_b (
    .clk(clk), .reset(b_reset), .start(b_start), .halt(b_halt), .fault(b_fault),
    .cpu_reset(b_cpu_reset), .running(b_running), .done(b_done), .status(b_status),
    .cycles(b_cycles), .halted_mask(b_halted_mask)
  );

  typedef struct {
    logic [1:0]  status;
    logic [15:0] cycles;
    logic [2:0]  mask;
  } exp_t;

  exp_t sb_a[$];
  exp_t sb_b[$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input bit sel, input logic [1:0] st, input int cyc, input logic [2:0] m);
    exp_t e;
    e.status = st;
    e.cycles = 16'(cyc);
    e.mask   = m;
    if (sel) sb_b.push_back(e);
    else     sb_a.push_back(e);
  endtask

  // Monitors: compare the finished run against the scoreboard when done rises.
  logic a_done_prev = 1'b0;
  logic b_done_prev = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (a_done === 1'b1 && a_done_prev !== 1'b1) begin
      if (sb_a.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL a_unexpected_done: got done=1 expected no run end");
      end else begin
        e = sb_a.pop_front();
        check("a_status", a_status, e.status);
        check("a_cycles", a_cycles, e.cycles);
        check("a_mask", a_halted_mask, e.mask);
        check("a_done_cpu_reset", a_cpu_reset, 1);
        check("a_done_running", a_running, 0);
      end
    end
    a_done_prev = a_done;
  end

  always @(negedge clk) begin
    exp_t e;
    if (b_done === 1'b1 && b_done_prev !== 1'b1) begin
      if (sb_b.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL b_unexpected_done: got done=1 expected no run end");
      end else begin
        e = sb_b.pop_front();
        check("b_status", b_status, e.status);
        check("b_cycles", b_cycles, e.cycles);
        check("b_mask", b_halted_mask, e.mask);
        check("b_done_cpu_reset", b_cpu_reset, 1);
        check("b_done_running", b_running, 0);
      end
    end
    b_done_prev = b_done;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic sel_running(input bit sel);
    return sel ? b_running : a_running;
  endfunction

  function automatic logic sel_done(input bit sel);
    return sel ? b_done : a_done;
  endfunction

  function automatic logic [15:0] sel_cycles(input bit sel);
    return sel ? b_cycles : a_cycles;
  endfunction

  // Counts edges until running rises; that count is the remaining RESET length.
  task automatic wait_run(input bit sel, input int exp_n, input string name);
    int n = 0;
    while (sel_running(sel) !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check(name, n, exp_n);
  endtask

  task automatic wait_done(input bit sel, input string name);
    int n = 0;
    while (sel_done(sel) !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    check(name, sel_done(sel), 1);
  endtask

  task automatic advance_to(input bit sel, input int target, input string name);
    int n = 0;
    while (sel_cycles(sel) !== 16'(target) && n < 400) begin
      tick();
      n++;
    end
    check(name, sel_cycles(sel), target);
  endtask

  task automatic check_idle_a(input string name);
    check({name, "_cpu_reset"}, a_cpu_reset, 1);
    check({name, "_running"}, a_running, 0);
    check({name, "_done"}, a_done, 0);
    check({name, "_status"}, a_status, 0);
    check({name, "_cycles"}, a_cycles, 0);
    check({name, "_mask"}, a_halted_mask, 0);
  endtask

  initial begin
    a_reset = 1'b1; a_start = 1'b0; a_halt = '0; a_fault = '0;
    b_reset = 1'b1; b_start = 1'b0; b_halt = '0; b_fault = '0;
    tick();
    tick();
    check_idle_a("t1_reset");
    a_reset = 1'b0;
    b_reset = 1'b0;

    // Test 1: start at cycle 3, all cores halted in RUN cycle 20.
    tick(); tick(); tick();
    a_start = 1'b1; tick(); a_start = 1'b0;
    check("t1_in_reset_cpu_reset", a_cpu_reset, 1);
    check("t1_in_reset_running", a_running, 0);
    wait_run(0, 2, "t1_reset_len");
    check("t1_run_cpu_reset", a_cpu_reset, 0);
    check("t1_run_cycles0", a_cycles, 0);
    advance_to(0, 19, "t1_adv19");
    a_halt = 1'b1;
    push(0, 2'b01, 20, 3'b001);
    tick();
    a_halt = 1'b0;
    wait_done(0, "t1_done");
    tick(); tick(); tick();
    check("t1_hold_cycles", a_cycles, 20);
    check("t1_hold_status", a_status, 2'b01);
    check("t1_hold_done", a_done, 1);

    // Test 2: timeout, then restart from DONE clears the result.
    a_start = 1'b1; tick(); a_start = 1'b0;
    check("t2_clr_cycles", a_cycles, 0);
    check("t2_clr_status", a_status, 0);
    check("t2_clr_done", a_done, 0);
    check("t2_clr_mask", a_halted_mask, 0);
    check("t2_clr_cpu_reset", a_cpu_reset, 1);
    wait_run(0, 2, "t2_reset_len");
    push(0, 2'b11, 250, 3'b000);
    wait_done(0, "t2_done");

    // Test 5: start ignored in RESET and RUN, reset aborts the run.
    a_start = 1'b1; tick(); a_start = 1'b0;
    a_start = 1'b1; tick(); a_start = 1'b0;
    wait_run(0, 1, "t5_reset_len_start_ignored");
    advance_to(0, 5, "t5_adv5");
    a_start = 1'b1; tick(); a_start = 1'b0;
    check("t5_run_start_cycles", a_cycles, 6);
    check("t5_run_start_running", a_running, 1);
    advance_to(0, 9, "t5_adv9");
    a_reset = 1'b1; tick(); a_reset = 1'b0;
    check_idle_a("t5_abort");
    tick();
    check_idle_a("t5_idle_hold");

    // Test 4b: halt completing in the timeout cycle is a pass.
    a_start = 1'b1; tick(); a_start = 1'b0;
    wait_run(0, 2, "t4b_reset_len");
    advance_to(0, 249, "t4b_adv249");
    a_halt = 1'b1;
    push(0, 2'b01, 250, 3'b001);
    tick();
    a_halt = 1'b0;
    wait_done(0, "t4b_done");

    // Test 3 (3 cores): halt/fault outside RUN ignored, staggered halt pulses.
    b_halt = 3'b111; b_fault = 3'b111; tick(); b_halt = '0; b_fault = '0;
    check("t3_idle_mask", b_halted_mask, 0);
    check("t3_idle_status", b_status, 0);
    check("t3_idle_running", b_running, 0);
    b_start = 1'b1; tick(); b_start = 1'b0;
    b_halt = 3'b001; tick(); b_halt = '0;
    check("t3_reset_mask", b_halted_mask, 0);
    wait_run(1, 1, "t3_reset_len");
    advance_to(1, 4, "t3_adv4");
    b_halt = 3'b001; tick(); b_halt = '0;
    check("t3_mask_001", b_halted_mask, 3'b001);
    check("t3_cycles5", b_cycles, 5);
    advance_to(1, 8, "t3_adv8");
    b_halt = 3'b100; tick(); b_halt = '0;
    check("t3_mask_101", b_halted_mask, 3'b101);
    check("t3_running", b_running, 1);
    advance_to(1, 13, "t3_adv13");
    b_halt = 3'b010;
    push(1, 2'b01, 14, 3'b111);
    tick();
    b_halt = '0;
    wait_done(1, "t3_done");

    // Test 4a: fault and full halt in the same cycle -> fault wins.
    b_start = 1'b1; tick(); b_start = 1'b0;
    wait_run(1, 2, "t4a_reset_len");
    advance_to(1, 6, "t4a_adv6");
    b_fault = 3'b010; b_halt = 3'b111;
    push(1, 2'b10, 7, 3'b111);
    tick();
    b_fault = '0; b_halt = '0;
    wait_done(1, "t4a_done");
    b_fault = 3'b111; tick(); b_fault = '0;
    check("t4a_done_fault_ignored_status", b_status, 2'b10);
    check("t4a_done_fault_ignored_cycles", b_cycles, 7);

    tick();
    check("sb_a_empty", sb_a.size(), 0);
    check("sb_b_empty", sb_b.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
